mul_acc_unsigned: RTL and testbench
===================================

Name: mul_acc_unsigned

Overview:
- Accumulation stage placed directly downstream of the combinational unsigned multiplier. It consumes a stream of 2*WIDTH-bit products and sums them into a frame result.
- The result is saturating, with a sticky overflow flag and a term count. It is presented on a held valid/ready output.
- Turns the multiplier into a dot-product / MAC datapath for the lab designs.

Parameters:
- WIDTH, 8: operand width of the upstream multiplier; product input is 2*WIDTH bits.
- ACC_WIDTH, 24: accumulator/result width; must be >= 2*WIDTH.
- CNT_WIDTH, 8: width of the term counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_prod  input  2*WIDTH  product from upstream multiplier (z).
- in_valid  input  1  in_prod valid this cycle.
- in_last  input  1  qualifies the final term of a frame; sampled with in_valid.
- in_ready  output  1  stage can accept a term.
- clr  input  1  discard the partial frame.
- out_data  output  ACC_WIDTH  frame sum, saturated.
- out_cnt  output  CNT_WIDTH  number of terms in the frame.
- out_ovf  output  1  frame sum saturated.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.

Behaviour:
- Reset: the block is synchronous, active-high, single clock.
  - Reset values: state=ACC, acc=0, cnt=0, ovf=0, out_data=0, out_cnt=0, out_ovf=0, out_valid=0.
  - in_ready is 1 in the cycle after rst deasserts.
  - Reset mid-frame or with a result pending drops everything; no result is emitted.
- FSM has two states.
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1; out_data/out_cnt/out_ovf are held stable until the handshake.
- Term accept occurs when in_valid & in_ready.
  - sum = acc + zero-extended in_prod, computed at ACC_WIDTH+1 bits.
  - If sum[ACC_WIDTH] is set, or ovf is already set: next acc = all-ones (2^ACC_WIDTH-1) and ovf=1. Otherwise next acc = sum[ACC_WIDTH-1:0].
  - cnt increments by 1, saturating at 2^CNT_WIDTH-1 (no wrap).
- Last term (accept & in_last):
  - out_data <= next acc; out_cnt <= next cnt; out_ovf <= next ovf.
  - acc/cnt/ovf cleared to 0; state -> DONE.
  - Latency: out_valid asserts the cycle after the last term is accepted.
- DONE: when out_valid & out_ready, state -> ACC and in_ready=1 next cycle. There is no bypass: minimum one bubble cycle per frame.
- out_ready while out_valid=0 has no effect.
- A single-term frame (in_last on the first beat) gives out_data=in_prod, out_cnt=1.
- clr in ACC: acc/cnt/ovf go to 0 next cycle.
  - If it coincides with an accepted term, clr wins: the term is consumed (in_ready stays 1) but not added, and in_last is ignored (no result).
- clr in DONE: ignored; the pending result is not disturbed.
- in_valid=0 cycles inside a frame leave acc/cnt unchanged; in_last without in_valid is ignored.
- The upstream product is combinational. This stage registers nothing on the input side, so the in_prod path is the critical path into the adder.

Test Plan:
- Reset then 3-term frame: WIDTH=8, ACC_WIDTH=24, products 6, 20, 100 with last on the third, out_ready=1 -> out_valid pulses one cycle after beat 3 with out_data=126, out_cnt=3, out_ovf=0. in_ready is 0 for exactly that cycle.
- Saturation: ACC_WIDTH=18, five beats of 65025 (255*255).
  - After 4 beats acc=260100.
  - 5th with last -> out_data=262143, out_ovf=1, out_cnt=5.
  - Next frame of a single 1 -> out_data=1, ovf=0.
- Backpressure: frame 7, 8 (last) with out_ready=0 for 5 cycles.
  - out_valid=1 with out_data=15 and out_cnt=2 stable for all 5 cycles; in_ready=0 throughout, and in_valid pulses are not consumed.
  - Raising out_ready -> in_ready=1 the next cycle.
- clr collision: beats 10, 20, then 30 with in_last and clr in the same cycle.
  - No out_valid.
  - A following frame 5 (last) -> out_data=5, out_cnt=1.
- Reset mid-frame and in DONE:
  - rst after 2 beats -> no output and acc restarts at 0.
  - rst while out_valid=1 -> out_valid=0 next cycle, out_data=0.
- Counter saturation: CNT_WIDTH=4, 20 beats of 1 (last on the 20th) -> out_cnt=15, out_data=20.

Source files
------------

// File: rtl/mul_acc_unsigned.sv
// mul_acc_unsigned: saturating accumulator of unsigned products into framed results with valid/ready output
module mul_acc_unsigned #(
  parameter int WIDTH = 8,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*WIDTH-1:0]     in_prod,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   clr,
  output logic [ACC_WIDTH-1:0]   out_data,
  output logic [CNT_WIDTH-1:0]   out_cnt,
  output logic                   out_ovf,
  output logic                   out_valid,
  input  logic                   out_ready
);
  typedef enum logic {ACC, DONE} state_t;
  state_t state, state_nx;
  logic [ACC_WIDTH-1:0] acc, acc_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic ovf, ovf_nx, accept, take;
  logic [ACC_WIDTH:0] sum;
  assign in_ready = state == ACC;
  assign out_valid = state == DONE;
  assign accept = in_valid & in_ready;
  assign take = accept & ~clr;
  // one extra bit catches the carry out of the accumulator
  assign sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, in_prod};
  always_comb begin
    ovf_nx = sum[ACC_WIDTH] | ovf;
    acc_nx = ovf_nx ? '1 : sum[ACC_WIDTH-1:0];
    cnt_nx = &cnt ? cnt : cnt + 1'b1;
    state_nx = state;
    if (state == ACC && take && in_last) state_nx = DONE;
    if (state == DONE && out_ready) state_nx = ACC;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_data <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_ready && clr) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (take && in_last) begin
        out_data <= acc_nx;
        out_cnt <= cnt_nx;
        out_ovf <= ovf_nx;
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (take) begin
        acc <= acc_nx;
        cnt <= cnt_nx;
        ovf <= ovf_nx;
      end
    end
  end
endmodule

// File: tb/tb_mul_acc_unsigned.sv
// tb_mul_acc_unsigned: directed and random frames checked against an arithmetic frame model
module tb_mul_acc_unsigned;
  localparam int W = 8, AW = 24, CW = 8;
  localparam longint AMAX = (longint'(1) << AW) - 1;
  localparam longint CMAX = (longint'(1) << CW) - 1;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, in_valid = 0, in_last = 0, clr = 0, out_ready = 0;
  logic [2*W-1:0] in_prod = '0;
  logic in_ready, out_ovf, out_valid;
  logic [AW-1:0] out_data;
  logic [CW-1:0] out_cnt;
  int total = 0, bad = 0;
  bit m_done = 0, m_ovf = 0, m_ovf_o = 0;
  longint m_acc = 0, m_cnt = 0, m_data = 0, m_cnt_o = 0;

  mul_acc_unsigned #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_prod(in_prod), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .clr(clr), .out_data(out_data), .out_cnt(out_cnt),
    .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready));

  task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endtask

  task automatic check();
    cmp("in_ready", 64'(in_ready), 64'(!m_done));
    cmp("out_valid", 64'(out_valid), 64'(m_done));
    if (m_done) begin
      cmp("out_data", 64'(out_data), m_data);
      cmp("out_cnt", 64'(out_cnt), m_cnt_o);
      cmp("out_ovf", 64'(out_ovf), 64'(m_ovf_o));
    end
  endtask

  task automatic step(input bit v, input longint p, input bit l, input bit c, input bit r, input bit rs);
    longint s;
    @(negedge clk);
    check();
    in_valid = v; in_prod = p[2*W-1:0]; in_last = l; clr = c; out_ready = r; rst = rs;
    if (rs) begin
      m_done = 0; m_acc = 0; m_cnt = 0; m_ovf = 0; m_data = 0; m_cnt_o = 0; m_ovf_o = 0;
    end else if (m_done) begin
      if (r) m_done = 0;
    end else if (c) begin
      m_acc = 0; m_cnt = 0; m_ovf = 0;
    end else if (v) begin
      s = m_acc + (p & 64'hFFFF);
      m_ovf = m_ovf || s > AMAX;
      m_acc = m_ovf ? AMAX : s;
      m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX;
      if (l) begin
        m_data = m_acc; m_cnt_o = m_cnt; m_ovf_o = m_ovf; m_done = 1;
        m_acc = 0; m_cnt = 0; m_ovf = 0;
      end
    end
  endtask

  task automatic beat(input longint p, input bit l);
    step(1, p, l, 0, 0, 0);
  endtask

  task automatic idle(input bit r);
    step(0, 0, 0, 0, r, 0);
  endtask

  task automatic pin(input string n, input longint d, input longint c, input bit o);
    cmp({n, "_valid"}, 64'(out_valid), 1);
    cmp({n, "_data"}, 64'(out_data), d);
    cmp({n, "_cnt"}, 64'(out_cnt), c);
    cmp({n, "_ovf"}, 64'(out_ovf), 64'(o));
    cmp({n, "_model"}, m_data, d);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    cmp("rst_in_ready", 64'(in_ready), 1);
    cmp("rst_out_data", 64'(out_data), 0);
    beat(6, 0); beat(20, 0); beat(100, 1);
    idle(1);
    pin("f3", 126, 3, 0);
    cmp("f3_in_ready", 64'(in_ready), 0);
    idle(0);
    cmp("f3_ready_back", 64'(in_ready), 1);
    cmp("f3_valid_gone", 64'(out_valid), 0);
    for (int i = 0; i < 258; i++) beat(65025, 0);
    beat(765, 1);
    idle(1);
    pin("exact_max", AMAX, CMAX, 0);
    for (int i = 0; i < 260; i++) beat(65025, i == 259);
    idle(1);
    pin("sat", AMAX, CMAX, 1);
    beat(1, 1); idle(1);
    pin("after_sat", 1, 1, 0);
    beat(7, 0); beat(8, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 99, 1, 0, 0, 0);
      pin("bp", 15, 2, 0);
      cmp("bp_in_ready", 64'(in_ready), 0);
    end
    idle(1);
    idle(0);
    cmp("bp_release", 64'(in_ready), 1);
    beat(3, 1); idle(1);
    pin("bp_next", 3, 1, 0);
    beat(10, 0); beat(20, 0); step(1, 30, 1, 1, 1, 0);
    idle(1);
    cmp("clr_no_valid", 64'(out_valid), 0);
    beat(5, 1); idle(1);
    pin("clr_next", 5, 1, 0);
    beat(40, 0); beat(50, 0); step(0, 0, 0, 0, 0, 1);
    idle(1);
    cmp("rst_mid_valid", 64'(out_valid), 0);
    beat(4, 1); idle(1);
    pin("rst_mid_next", 4, 1, 0);
    beat(9, 1); idle(0);
    pin("pre_rst", 9, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(0);
    cmp("rst_done_valid", 64'(out_valid), 0);
    cmp("rst_done_data", 64'(out_data), 0);
    beat(2, 1); step(0, 0, 0, 1, 0, 0);
    idle(1);
    pin("clr_in_done", 2, 1, 0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0 ? 65535 : $urandom_range(0, 65535),
           $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 499) == 0);
    idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
